// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl
//   Byte-serial NBYTES-wide adder controller. It time-multiplexes one external
//   8-bit combinational adder, which has no carry-in, feeding it one byte per
//   cycle, LSB first. The carry is chained in this block.
//
//   Optional feature macro: ADDER_SEQ_SUB_EN
//     When defined, an 'op' input is added (0=add, 1=subtract). Subtraction
//     feeds ~B bytes with an initial carry of 1. cout=1 then means "no borrow".
//
//   Ports
//     clk, rst_n         clock, asynchronous active-low reset
//     in_valid/in_ready  operand handshake; a, b (and op) sampled on transfer
//     add_x, add_y       current byte pair to the external adder (0 outside RUN)
//     add_sum, add_carry external adder result for add_x/add_y
//     out_valid/out_ready result handshake; sum, cout held stable in DONE
module adder_seq_ctrl #(
  parameter  int NBYTES = 4,
  localparam int W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
`ifdef ADDER_SEQ_SUB_EN
  input  logic         op,
`endif
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [7:0]   add_x,
  output logic [7:0]   add_y,
  input  logic [7:0]   add_sum,
  input  logic         add_carry,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [NBYTES-1:0][7:0]   a_q, a_d;
  logic [NBYTES-1:0][7:0]   b_q, b_d;
  logic [NBYTES-1:0][7:0]   res_q, res_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     cin_q, cin_d;
  logic                     cout_q, cout_d;

  logic                     sub_op;
  logic [7:0]               byte_res;
  logic                     c_next;

`ifdef ADDER_SEQ_SUB_EN
  assign sub_op = op;
`else
  assign sub_op = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    idx_d    = idx_q;
    cin_d    = cin_q;
    cout_d   = cout_q;
    add_x    = 8'h00;
    add_y    = 8'h00;
    // The external adder has no carry-in, so the carry is folded in here.
    // A carry out of this increment only happens when add_sum is FF, which
    // requires add_carry=0, so the OR never sees both terms set.
    byte_res = add_sum + {7'b0, cin_q};
    c_next   = add_carry | (cin_q & (add_sum == 8'hFF));

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          // Subtraction is a + ~b + 1: invert B once at capture.
          b_d     = sub_op ? ~b : b;
          idx_d   = '0;
          cin_d   = sub_op;
          state_d = RUN;
        end
      end
      RUN: begin
        add_x        = a_q[0];
        add_y        = b_q[0];
        res_d[idx_q] = byte_res;
        cin_d        = c_next;
        a_d          = a_q >> 8;
        b_d          = b_q >> 8;
        idx_d        = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          cout_d  = c_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      cin_q   <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      cin_q   <= cin_d;
      cout_q  <= cout_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = res_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
module tb_adder_seq_ctrl;
  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a, b;
  logic [7:0]   add_x, add_y, add_sum;
  logic         add_carry;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Model of the external 8-bit adder: combinational, no carry-in.
  assign {add_carry, add_sum} = {1'b0, add_x} + {1'b0, add_y};

  adder_seq_ctrl #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef ADDER_SEQ_SUB_EN
    .op        (op),
`endif
    .a         (a),
    .b         (b),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_sum   (add_sum),
    .add_carry (add_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  // Drive one operation with out_ready held low; return what was seen once
  // out_valid rose and the number of edges after the input handshake.
  // Leaves the DUT in DONE.
  task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vop, output int lat,
                          output logic [7:0] x0, output logic [7:0] y0,
                          output logic rdy_run);
    @(negedge clk);
    a = va; b = vb; op = vop; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);          // handshake edge k has passed
    in_valid = 1'b0;
    x0 = add_x; y0 = add_y; rdy_run = in_ready;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0; a = '0; b = '0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 ||
        add_x !== 8'h00 || add_y !== 8'h00) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b sum=%h cout=%b x=%h y=%h (want 1 0 0 0 0 0)",
               in_ready, out_valid, sum, cout, add_x, add_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [W-1:0] va [3] = '{32'h000000FF, 32'hFFFFFFFF, 32'h00FFFFFF};
    logic [W-1:0] vb [3] = '{32'h00000001, 32'h00000001, 32'h00000001};
    logic [W-1:0] es [3] = '{32'h00000100, 32'h00000000, 32'h01000000};
    logic         ec [3] = '{1'b0, 1'b1, 1'b0};
    int lat; logic [7:0] x0, y0; logic rr;
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i], 1'b0, lat, x0, y0, rr);
      checks++;
      if (lat !== NBYTES) begin
        failures++; $display("FAIL add%0d_latency: got %0d want %0d", i, lat, NBYTES);
      end
      checks++;
      if (x0 !== va[i][7:0] || y0 !== vb[i][7:0] || rr !== 1'b0) begin
        failures++;
        $display("FAIL add%0d_run: x=%h y=%h in_ready=%b want %h %h 0", i, x0, y0, rr,
                 va[i][7:0], vb[i][7:0]);
      end
      checks++;
      if (sum !== es[i] || cout !== ec[i] || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL add%0d_result: sum=%h cout=%b in_ready=%b want %h %b 0",
                 i, sum, cout, in_ready, es[i], ec[i]);
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [7:0] x0, y0; logic rr;
    start_op(32'h12345678, 32'h11111111, 1'b0, lat, x0, y0, rr);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sum !== 32'h23456789 || cout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: sum=%h cout=%b ov=%b ir=%b want 23456789 0 1 0",
                 i, sum, cout, out_valid, in_ready);
      end
      @(negedge clk);
    end
    finish_op();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [3] = '{32'h00000003, 32'h80000000, 32'hDEADBEEF};
    logic [W-1:0] vb [3] = '{32'h00000004, 32'h80000000, 32'h01010101};
    logic [W-1:0] es [3] = '{32'h00000007, 32'h00000000, 32'hDFAEBFF0};
    logic         ec [3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] gs [3];
    logic         gc [3];
    int           gt [3];
    int           n = 0;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          a = va[i]; b = vb[i]; op = 1'b0; in_valid = 1'b1;
          for (int g = 0; g < 50 && !in_ready; g++) @(negedge clk);
        end
        @(negedge clk);
        // Junk operands left on the bus while in_valid drops.
        a = 32'hAAAAAAAA; b = 32'h55555555; in_valid = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 100 && n < 3; cyc++) begin
          @(negedge clk);
          if (out_valid) begin
            gs[n] = sum; gc[n] = cout; gt[n] = cyc; n++;
          end
        end
      end
    join
    out_ready = 1'b0;
    checks++;
    if (n !== 3) begin
      failures++; $display("FAIL b2b_count: got %0d results want 3", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (gs[i] !== es[i] || gc[i] !== ec[i]) begin
        failures++;
        $display("FAIL b2b_result%0d: sum=%h cout=%b want %h %b", i, gs[i], gc[i], es[i], ec[i]);
      end
    end
    for (int i = 1; i < n; i++) begin
      checks++;
      if (gt[i] - gt[i-1] !== NBYTES + 2) begin
        failures++;
        $display("FAIL b2b_spacing%0d: got %0d want %0d", i, gt[i] - gt[i-1], NBYTES + 2);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [7:0] x0, y0; logic rr;
    @(negedge clk);
    a = 32'h11223344; b = 32'h01010101; op = 1'b0; in_valid = 1'b1;
    @(negedge clk);          // idx 0 in progress
    in_valid = 1'b0;
    @(negedge clk);          // idx 1
    @(negedge clk);          // idx 2
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== '0 || add_x !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_run: ov=%b ir=%b sum=%h x=%h want 0 1 0 0",
               out_valid, in_ready, sum, add_x);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'h00000001, 32'h00000002, 1'b0, lat, x0, y0, rr);
    checks++;
    if (lat !== NBYTES || sum !== 32'h00000003 || cout !== 1'b0) begin
      failures++;
      $display("FAIL rst_recover: lat=%0d sum=%h cout=%b want %0d 00000003 0",
               lat, sum, cout, NBYTES);
    end
    finish_op();
  endtask

`ifdef ADDER_SEQ_SUB_EN
  task automatic test_sub();
    logic [W-1:0] va [2] = '{32'h00000000, 32'h00000005};
    logic [W-1:0] vb [2] = '{32'h00000001, 32'h00000003};
    logic [W-1:0] es [2] = '{32'hFFFFFFFF, 32'h00000002};
    logic         ec [2] = '{1'b0, 1'b1};
    int lat; logic [7:0] x0, y0; logic rr;
    for (int i = 0; i < 2; i++) begin
      start_op(va[i], vb[i], 1'b1, lat, x0, y0, rr);
      checks++;
      if (sum !== es[i] || cout !== ec[i] || y0 !== ~vb[i][7:0]) begin
        failures++;
        $display("FAIL sub%0d: sum=%h cout=%b y0=%h want %h %b %h",
                 i, sum, cout, y0, es[i], ec[i], ~vb[i][7:0]);
      end
      finish_op();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
`ifdef ADDER_SEQ_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
